// File: rtl/multiplier.sv
// Unsigned C_WIDTH x C_WIDTH multiplier with a fixed-point output shift and three
// selectable architectures: single-cycle, radix-2 shift-add, or radix-4 shift-add.
module multiplier #(
    parameter int C_WIDTH     = 8,
    parameter int FIXED_POINT = 0,
    parameter int MUL_TYPE    = 0
) (
    input  logic                   ctl_clk,
    input  logic                   reset,
    input  logic [C_WIDTH-1:0]     a,
    input  logic [C_WIDTH-1:0]     b,
    input  logic                   trigger,
    output logic [2*C_WIDTH-1:0]   y,
    output logic                   ready,
    output logic                   done
);

    localparam int PW   = 2 * C_WIDTH;
    // Unknown architecture codes fall back to the single-cycle datapath.
    localparam int ARCH = (MUL_TYPE == 1 || MUL_TYPE == 2) ? MUL_TYPE : 0;
    localparam int LAT  = (ARCH == 1) ? C_WIDTH : ((ARCH == 2) ? C_WIDTH / 2 : 1);
    localparam int CW   = $clog2(C_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [C_WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     y_q, y_d;
    logic              done_q, done_d;

    logic [PW-1:0]     full_prod;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     prod_next;

    // Partial product for the current step; the multiplicand is pre-shifted each cycle.
    always_comb begin
        pp        = '0;
        full_prod = mcand_q * PW'(mplier_q);
        if (ARCH == 2) begin
            case (mplier_q[1:0])
                2'd0:    pp = '0;
                2'd1:    pp = mcand_q;
                2'd2:    pp = mcand_q << 1;
                default: pp = (mcand_q << 1) + mcand_q;
            endcase
        end else begin
            pp = mplier_q[0] ? mcand_q : '0;
        end
        acc_sum   = acc_q + pp;
        prod_next = (ARCH == 0) ? full_prod : acc_sum;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (ARCH == 1) begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else if (ARCH == 2) begin
                    mcand_d  = mcand_q << 2;
                    mplier_d = mplier_q >> 2;
                end
                acc_d = acc_sum;
                if (cnt_q == LAST) begin
                    y_d     = prod_next >> FIXED_POINT;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            done_q   <= done_d;
        end
    end

    assign y     = y_q;
    assign done  = done_q;
    assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: five instances covering every architecture, an illegal
// architecture code and a fixed-point shift, all driven from shared operand buses.
module tb_multiplier;

    logic        clk;
    logic        reset;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        trig   [5];
    logic [15:0] y_s    [5];
    logic        ready_s[5];
    logic        done_s [5];

    // Per-instance latency and whether the instance uses FIXED_POINT=4.
    int lat [5] = '{1, 8, 4, 4, 1};
    bit fp4 [5] = '{0, 0, 0, 1, 1};

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiplier #(.C_WIDTH(8), .FIXED_POINT(0), .MUL_TYPE(0)) u0 (
        .ctl_clk(clk), .reset(reset), .a(a_in), .b(b_in), .trigger(trig[0]),
        .y(y_s[0]), .ready(ready_s[0]), .done(done_s[0]));
    multiplier #(.C_WIDTH(8), .FIXED_POINT(0), .MUL_TYPE(1)) u1 (
        .ctl_clk(clk), .reset(reset), .a(a_in), .b(b_in), .trigger(trig[1]),
        .y(y_s[1]), .ready(ready_s[1]), .done(done_s[1]));
    multiplier #(.C_WIDTH(8), .FIXED_POINT(0), .MUL_TYPE(2)) u2 (
        .ctl_clk(clk), .reset(reset), .a(a_in), .b(b_in), .trigger(trig[2]),
        .y(y_s[2]), .ready(ready_s[2]), .done(done_s[2]));
    multiplier #(.C_WIDTH(8), .FIXED_POINT(4), .MUL_TYPE(2)) u3 (
        .ctl_clk(clk), .reset(reset), .a(a_in), .b(b_in), .trigger(trig[3]),
        .y(y_s[3]), .ready(ready_s[3]), .done(done_s[3]));
    multiplier #(.C_WIDTH(8), .FIXED_POINT(4), .MUL_TYPE(3)) u4 (
        .ctl_clk(clk), .reset(reset), .a(a_in), .b(b_in), .trigger(trig[4]),
        .y(y_s[4]), .ready(ready_s[4]), .done(done_s[4]));

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) trig[i] = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (y_s[i] !== 16'h0000 || done_s[i] !== 1'b0 || ready_s[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset inst%0d: y=%h done=%b ready=%b, want y=0000 done=0 ready=1",
                         i, y_s[i], done_s[i], ready_s[i]);
            end
        end
    endtask

    // Trigger every instance with the same operands and scramble a/b while busy.
    task automatic run_all(input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] e0, input logic [15:0] e4, input string name);
        int done_at[5];
        int ndone[5];
        logic [15:0] exp_y;
        for (int i = 0; i < 5; i++) begin
            done_at[i] = -1;
            ndone[i]   = 0;
        end
        a_in = av;
        b_in = bv;
        for (int i = 0; i < 5; i++) trig[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) trig[i] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            a_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            for (int i = 0; i < 5; i++) begin
                exp_y = fp4[i] ? e4 : e0;
                if (k < lat[i]) begin
                    total++;
                    if (ready_s[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s busy_ready inst%0d k=%0d: ready=%b, want 0",
                                 name, i, k, ready_s[i]);
                    end
                end
                if (done_s[i] === 1'b1) begin
                    ndone[i]++;
                    done_at[i] = k;
                    total++;
                    if (y_s[i] !== exp_y || ready_s[i] !== 1'b1) begin
                        bad++;
                        $display("FAIL %s y inst%0d: y=%h ready=%b, want y=%h ready=1",
                                 name, i, y_s[i], ready_s[i], exp_y);
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            exp_y = fp4[i] ? e4 : e0;
            total++;
            if (ndone[i] != 1 || done_at[i] != lat[i] || y_s[i] !== exp_y) begin
                bad++;
                $display("FAIL %s timing inst%0d: dones=%0d at=%0d y=%h, want 1 at %0d y=%h",
                         name, i, ndone[i], done_at[i], y_s[i], lat[i], exp_y);
            end
        end
    endtask

    task automatic test_products;
        run_all(8'h03, 8'h02, 16'h0006, 16'h0000, "small");
        run_all(8'h24, 8'h70, 16'h0FC0, 16'h00FC, "fixed");
        run_all(8'hFF, 8'hFF, 16'hFE01, 16'h0FE0, "max");
        run_all(8'h00, 8'hFF, 16'h0000, 16'h0000, "zero");
        run_all(8'hA5, 8'h3C, 16'h26AC, 16'h026A, "mixed");
    endtask

    task automatic test_busy_trigger;
        int n = 0;
        int at = -1;
        a_in = 8'h24;
        b_in = 8'h70;
        trig[1] = 1'b1;
        @(posedge clk);
        #1;
        trig[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            trig[1] = (k == 2);
            if (done_s[1] === 1'b1) begin
                n++;
                at = k;
            end
        end
        trig[1] = 1'b0;
        total++;
        if (n != 1 || at != 8 || y_s[1] !== 16'h0FC0) begin
            bad++;
            $display("FAIL busy_trigger: dones=%0d at=%0d y=%h, want 1 at 8 y=0fc0", n, at, y_s[1]);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int first_k = -1;
        int second_k = -1;
        a_in = 8'h03;
        b_in = 8'h02;
        trig[1] = 1'b1;
        @(posedge clk);
        #1;
        trig[1] = 1'b0;
        a_in = 8'hEE;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            trig[1] = 1'b0;
            if (k == 10) a_in = 8'h11;
            if (k == 12) begin
                total++;
                if (y_s[1] !== 16'h0006) begin
                    bad++;
                    $display("FAIL hold_y: y=%h, want 0006", y_s[1]);
                end
            end
            if (done_s[1] === 1'b1) begin
                n++;
                if (first_k < 0) begin
                    first_k = k;
                    a_in = 8'h05;
                    b_in = 8'h07;
                    trig[1] = 1'b1;
                end else begin
                    second_k = k;
                    total++;
                    if (y_s[1] !== 16'h0023) begin
                        bad++;
                        $display("FAIL b2b_second_y: y=%h, want 0023", y_s[1]);
                    end
                end
            end
        end
        total++;
        if (n != 2 || first_k != 8 || second_k != 17) begin
            bad++;
            $display("FAIL b2b_timing: dones=%0d at %0d,%0d, want 2 at 8,17", n, first_k, second_k);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        a_in = 8'hFF;
        b_in = 8'hFF;
        trig[1] = 1'b1;
        @(posedge clk);
        #1;
        trig[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            reset = (k == 3);
            if (done_s[1] === 1'b1) n++;
            if (k == 4) begin
                total++;
                if (y_s[1] !== 16'h0000 || ready_s[1] !== 1'b1 || done_s[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid: y=%h ready=%b done=%b, want 0000 1 0",
                             y_s[1], ready_s[1], done_s[1]);
                end
            end
        end
        total++;
        if (n != 0 || y_s[1] !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_abort: dones=%0d y=%h, want 0 dones y=0000", n, y_s[1]);
        end
    endtask

    task automatic test_reset_with_trigger;
        int n = 0;
        a_in = 8'h24;
        b_in = 8'h70;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) trig[i] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) trig[i] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 5; i++) if (done_s[i] === 1'b1) n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ready_s[i] !== 1'b1 || y_s[i] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_trigger inst%0d: ready=%b y=%h, want 1 0000", i, ready_s[i], y_s[i]);
            end
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_trigger_done: dones=%0d, want 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_busy_trigger();
        test_back_to_back();
        test_reset_mid();
        run_all(8'h24, 8'h70, 16'h0FC0, 16'h00FC, "after_reset");
        test_reset_with_trigger();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
